// File: rtl/msgmii_rxrdsched_if.sv
// msgmii_rxrdsched_if
//   Bundles the rx rate-adaptation read scheduler's signals.
//   master : write-side converter / front-end view (drives speed, framing and
//            write strobes, observes the read schedule)
//   slave  : the scheduler itself
//   Inputs to scheduler : speed[1:0], frame_start, wr_phase[3:0], wr_cnt[1:0], rx_active
//   Outputs             : rd_addr[3:0], rd_valid, rd_sof, rd_eof, underrun, overrun
interface msgmii_rxrdsched_if;
   logic [1:0] speed;
   logic       frame_start;
   logic [3:0] wr_phase;
   logic [1:0] wr_cnt;
   logic       rx_active;
   logic [3:0] rd_addr;
   logic       rd_valid;
   logic       rd_sof;
   logic       rd_eof;
   logic       underrun;
   logic       overrun;

   modport master (
      output speed, frame_start, wr_phase, wr_cnt, rx_active,
      input  rd_addr, rd_valid, rd_sof, rd_eof, underrun, overrun
   );

   modport slave (
      input  speed, frame_start, wr_phase, wr_cnt, rx_active,
      output rd_addr, rd_valid, rd_sof, rd_eof, underrun, overrun
   );
endinterface

// File: rtl/msgmii_rxrdsched.sv
// msgmii_rxrdsched
//   Read-side scheduler for the SGMII rx rate-adaptation buffer (16 x 10-bit).
//   Tracks occupancy from write strobes, primes THRESH bytes, then issues one
//   buffer read index per line-rate tick (every clock at 1000M, every P_100M
//   or P_10M clocks otherwise), framing the bytes with sof/eof and flagging
//   underrun/overrun. All outputs are registered.
//   Ports:
//     clk   : receive clock, rising edge
//     reset : asynchronous active-high reset
//     bus   : msgmii_rxrdsched_if.slave (speed, frame_start, wr_phase, wr_cnt,
//             rx_active in; rd_addr, rd_valid, rd_sof, rd_eof, underrun,
//             overrun out)
module msgmii_rxrdsched #(
   parameter int THRESH = 4,
   parameter int P_100M = 10,
   parameter int P_10M  = 100
) (
   input  logic                clk,
   input  logic                reset,
   msgmii_rxrdsched_if.slave   bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PRIME  = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_FLUSH  = 2'd3;

   localparam logic [6:0] TOP_100M = 7'(P_100M - 1);
   localparam logic [6:0] TOP_10M  = 7'(P_10M - 1);
   localparam logic [5:0] THRESH_W = 6'(THRESH);

   logic [1:0] state_q,    state_d;
   logic [1:0] speed_l_q,  speed_l_d;
   logic [3:0] rd_ptr_q,   rd_ptr_d;
   logic [4:0] occ_q,      occ_d;
   logic [6:0] cnt_q,      cnt_d;
   logic       sof_pend_q, sof_pend_d;
   logic [3:0] rd_addr_q,  rd_addr_d;
   logic       rd_valid_q, rd_valid_d;
   logic       rd_sof_q,   rd_sof_d;
   logic       rd_eof_q,   rd_eof_d;
   logic       underrun_q, underrun_d;
   logic       overrun_q,  overrun_d;

   logic [1:0] wr_eff;
   logic       fast;
   logic [6:0] tick_top;
   logic       tick;
   logic       rd;
   logic [5:0] occ_sum;
   logic       ovf;

   always_comb begin
      wr_eff   = (bus.wr_cnt == 2'd3) ? 2'd2 : bus.wr_cnt;
      // speed 10 and 11 both run at gigabit rate
      fast     = speed_l_q[1];
      tick_top = (speed_l_q == 2'b01) ? TOP_100M : TOP_10M;
      tick     = fast | (cnt_q == tick_top);
      rd       = tick & (state_q == ST_STREAM) & (occ_q != 5'd0);
      // occ <= 16 and rd only when occ >= 1, so this never wraps below 0
      occ_sum  = {1'b0, occ_q} + {4'd0, wr_eff} - {5'd0, rd};
      ovf      = (occ_sum > 6'd16);

      state_d    = state_q;
      speed_l_d  = speed_l_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      cnt_d      = (fast || cnt_q == tick_top) ? 7'd0 : cnt_q + 7'd1;
      sof_pend_d = sof_pend_q;
      rd_addr_d  = rd_addr_q;
      rd_valid_d = 1'b0;
      rd_sof_d   = 1'b0;
      rd_eof_d   = 1'b0;
      underrun_d = 1'b0;
      overrun_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // rate is only sampled between frames
            speed_l_d = bus.speed;
            occ_d     = 5'd0;
            if (bus.frame_start) begin
               rd_ptr_d = bus.wr_phase;
               occ_d    = {3'd0, wr_eff};
               state_d  = ST_PRIME;
            end
         end

         ST_PRIME: begin
            occ_d = occ_sum[4:0];
            if (ovf) begin
               occ_d     = 5'd16;
               overrun_d = 1'b1;
               state_d   = ST_FLUSH;
            end else if (occ_sum >= THRESH_W || (!bus.rx_active && occ_sum != 6'd0)) begin
               // short frames that end before THRESH still drain
               state_d    = ST_STREAM;
               sof_pend_d = 1'b1;
               cnt_d      = 7'd0;
            end else if (!bus.rx_active) begin
               state_d = ST_IDLE;
            end
         end

         ST_STREAM: begin
            if (ovf) begin
               occ_d     = 5'd16;
               overrun_d = 1'b1;
               state_d   = ST_FLUSH;
            end else begin
               occ_d = occ_sum[4:0];
               if (rd) begin
                  rd_addr_d  = rd_ptr_q;
                  rd_ptr_d   = rd_ptr_q + 4'd1;
                  rd_valid_d = 1'b1;
                  rd_sof_d   = sof_pend_q;
                  sof_pend_d = 1'b0;
                  // last buffered byte of a finished frame, nothing arriving
                  if (occ_q == 5'd1 && !bus.rx_active && wr_eff == 2'd0) begin
                     rd_eof_d = 1'b1;
                     state_d  = ST_IDLE;
                  end
               end else if (tick && occ_q == 5'd0) begin
                  if (bus.rx_active) underrun_d = 1'b1;
                  else               state_d    = ST_IDLE;
               end
            end
         end

         default: begin // ST_FLUSH: discard the rest of the corrupted frame
            occ_d = 5'd0;
            if (!bus.rx_active) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         speed_l_q  <= 2'b10;
         rd_ptr_q   <= 4'd0;
         occ_q      <= 5'd0;
         cnt_q      <= 7'd0;
         sof_pend_q <= 1'b0;
         rd_addr_q  <= 4'd0;
         rd_valid_q <= 1'b0;
         rd_sof_q   <= 1'b0;
         rd_eof_q   <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         speed_l_q  <= speed_l_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         cnt_q      <= cnt_d;
         sof_pend_q <= sof_pend_d;
         rd_addr_q  <= rd_addr_d;
         rd_valid_q <= rd_valid_d;
         rd_sof_q   <= rd_sof_d;
         rd_eof_q   <= rd_eof_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.rd_addr  = rd_addr_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_sof   = rd_sof_q;
   assign bus.rd_eof   = rd_eof_q;
   assign bus.underrun = underrun_q;
   assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_msgmii_rxrdsched.sv
// tb_msgmii_rxrdsched
//   Directed bench for msgmii_rxrdsched. A negedge monitor logs every rd_valid
//   beat (cycle, addr, sof, eof) plus underrun/overrun pulses; each scenario
//   task drives a hand-built frame and compares the log with expected values.
module tb_msgmii_rxrdsched;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   cyc;

   typedef struct {
      int         cyc;
      logic [3:0] addr;
      logic       sof;
      logic       eof;
   } evt_t;

   evt_t evq[$];
   int   ur_cnt;
   int   or_cnt;
   int   or_cyc;

   msgmii_rxrdsched_if bus_if ();

   msgmii_rxrdsched #(.THRESH(4), .P_100M(10), .P_10M(100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus_if.rd_valid === 1'b1)
            evq.push_back('{cyc: cyc, addr: bus_if.rd_addr, sof: bus_if.rd_sof, eof: bus_if.rd_eof});
         if (bus_if.underrun === 1'b1) ur_cnt = ur_cnt + 1;
         if (bus_if.overrun === 1'b1) begin
            or_cnt = or_cnt + 1;
            or_cyc = cyc;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      evq.delete();
      ur_cnt = 0;
      or_cnt = 0;
      or_cyc = -1;
   endtask

   task automatic step(input logic fs, input logic [3:0] ph, input logic [1:0] wc, input logic act);
      @(negedge clk);
      bus_if.frame_start = fs;
      bus_if.wr_phase    = ph;
      bus_if.wr_cnt      = wc;
      bus_if.rx_active   = act;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_if.speed = 2'b10;
      bus_if.frame_start = 1'b0;
      bus_if.wr_phase = 4'h0;
      bus_if.wr_cnt = 2'd0;
      bus_if.rx_active = 1'b0;
      #1;
      checks++;
      if ({bus_if.rd_addr, bus_if.rd_valid, bus_if.rd_sof, bus_if.rd_eof, bus_if.underrun, bus_if.overrun} !== 9'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {bus_if.rd_addr, bus_if.rd_valid, bus_if.rd_sof,
                  bus_if.rd_eof, bus_if.underrun, bus_if.overrun});
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      clear_log();
      repeat (4) step(1'b0, 4'h0, 2'd2, 1'b1);
      step(1'b0, 4'h0, 2'd0, 1'b0);
      checks++;
      if (evq.size() !== 0 || bus_if.rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_ignores_writes events=%0d exp=0", evq.size());
      end
   endtask

   // Gigabit frame starting at E: wrap E,F,0..5, back-to-back beats
   task automatic test_1000m();
      logic [3:0] ea;
      int         fs_cyc;
      clear_log();
      bus_if.speed = 2'b10;
      step(1'b1, 4'hE, 2'd2, 1'b1);
      fs_cyc = cyc;
      repeat (3) step(1'b0, 4'h0, 2'd2, 1'b1);
      repeat (14) step(1'b0, 4'h0, 2'd0, 1'b0);
      checks++;
      if (evq.size() !== 8) begin
         failures++;
         $display("FAIL t1000_count got=%0d exp=8", evq.size());
      end else begin
         checks++;
         if (evq[0].cyc !== fs_cyc + 3) begin
            failures++;
            $display("FAIL t1000_latency got=%0d exp=%0d", evq[0].cyc - fs_cyc, 3);
         end
         ea = 4'hE;
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (evq[i].addr !== ea || evq[i].cyc !== evq[0].cyc + i ||
                evq[i].sof !== (i == 0) || evq[i].eof !== (i == 7)) begin
               failures++;
               $display("FAIL t1000_beat%0d got addr=%h cyc=+%0d sof=%b eof=%b exp addr=%h cyc=+%0d sof=%b eof=%b",
                        i, evq[i].addr, evq[i].cyc - evq[0].cyc, evq[i].sof, evq[i].eof,
                        ea, i, (i == 0), (i == 7));
            end
            ea = ea + 4'd1;
         end
      end
   endtask

   // 6-byte frame at the current 100M setting, beats 10 clocks apart
   task automatic run_frame6_100m(input logic [3:0] ph, input string tag);
      logic [3:0] ea;
      int         fs_cyc;
      clear_log();
      step(1'b1, ph, 2'd2, 1'b1);
      fs_cyc = cyc;
      repeat (2) step(1'b0, 4'h0, 2'd2, 1'b1);
      repeat (70) step(1'b0, 4'h0, 2'd0, 1'b0);
      checks++;
      if (evq.size() !== 6) begin
         failures++;
         $display("FAIL %s_count got=%0d exp=6", tag, evq.size());
      end else begin
         checks++;
         if (evq[0].cyc !== fs_cyc + 12) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=12", tag, evq[0].cyc - fs_cyc);
         end
         ea = ph;
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (evq[i].addr !== ea || evq[i].cyc !== evq[0].cyc + 10 * i ||
                evq[i].sof !== (i == 0) || evq[i].eof !== (i == 5)) begin
               failures++;
               $display("FAIL %s_beat%0d got addr=%h cyc=+%0d sof=%b eof=%b exp addr=%h cyc=+%0d",
                        tag, i, evq[i].addr, evq[i].cyc - evq[0].cyc, evq[i].sof, evq[i].eof, ea, 10 * i);
            end
            ea = ea + 4'd1;
         end
      end
   endtask

   task automatic test_100m();
      bus_if.speed = 2'b01;
      run_frame6_100m(4'h1, "t100");
   endtask

   // writes stall mid-frame: 5 beats, underrun every tick, resume without sof;
   // a stray frame_start during the stall must be ignored
   task automatic test_underrun();
      logic [3:0] ea;
      clear_log();
      bus_if.speed = 2'b10;
      step(1'b1, 4'h3, 2'd2, 1'b1);
      step(1'b0, 4'h0, 2'd2, 1'b1);
      step(1'b0, 4'h0, 2'd1, 1'b1);
      repeat (4) step(1'b0, 4'h0, 2'd0, 1'b1);
      step(1'b0, 4'h0, 2'd0, 1'b1);
      step(1'b1, 4'hF, 2'd0, 1'b1);
      step(1'b0, 4'h0, 2'd0, 1'b1);
      repeat (3) step(1'b0, 4'h0, 2'd1, 1'b1);
      repeat (10) step(1'b0, 4'h0, 2'd0, 1'b0);
      checks++;
      if (ur_cnt !== 4) begin
         failures++;
         $display("FAIL tur_underrun_count got=%0d exp=4", ur_cnt);
      end
      checks++;
      if (evq.size() !== 8) begin
         failures++;
         $display("FAIL tur_count got=%0d exp=8", evq.size());
      end else begin
         checks++;
         if (evq[5].cyc - evq[4].cyc !== 5) begin
            failures++;
            $display("FAIL tur_gap got=%0d exp=5", evq[5].cyc - evq[4].cyc);
         end
         ea = 4'h3;
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (evq[i].addr !== ea || evq[i].sof !== (i == 0) || evq[i].eof !== (i == 7)) begin
               failures++;
               $display("FAIL tur_beat%0d got addr=%h sof=%b eof=%b exp addr=%h sof=%b eof=%b",
                        i, evq[i].addr, evq[i].sof, evq[i].eof, ea, (i == 0), (i == 7));
            end
            ea = ea + 4'd1;
         end
      end
   endtask

   // 10M: 18 bytes arrive before the first tick -> overrun, flush, then a
   // short gigabit frame proves the block is back in IDLE
   task automatic test_overrun();
      int fs_cyc;
      clear_log();
      bus_if.speed = 2'b00;
      step(1'b1, 4'h0, 2'd2, 1'b1);
      fs_cyc = cyc;
      repeat (8) step(1'b0, 4'h0, 2'd2, 1'b1);
      repeat (2) step(1'b0, 4'h0, 2'd2, 1'b1);
      repeat (5) step(1'b0, 4'h0, 2'd0, 1'b0);
      checks++;
      if (or_cnt !== 1 || or_cyc !== fs_cyc + 9) begin
         failures++;
         $display("FAIL tor_overrun got count=%0d at=+%0d exp count=1 at=+9", or_cnt, or_cyc - fs_cyc);
      end
      checks++;
      if (evq.size() !== 0) begin
         failures++;
         $display("FAIL tor_no_reads got=%0d exp=0", evq.size());
      end
      clear_log();
      bus_if.speed = 2'b10;
      step(1'b1, 4'h9, 2'd2, 1'b1);
      repeat (8) step(1'b0, 4'h0, 2'd0, 1'b0);
      checks++;
      if (evq.size() !== 2) begin
         failures++;
         $display("FAIL tor_after_count got=%0d exp=2", evq.size());
      end else begin
         checks++;
         if (evq[0].addr !== 4'h9 || evq[0].sof !== 1'b1 || evq[1].addr !== 4'hA || evq[1].eof !== 1'b1) begin
            failures++;
            $display("FAIL tor_after_beats got %h/%b %h/%b exp 9/sof a/eof",
                     evq[0].addr, evq[0].sof, evq[1].addr, evq[1].eof);
         end
      end
   endtask

   task automatic test_reset_midframe();
      bit found;
      found = 1'b0;
      bus_if.speed = 2'b10;
      step(1'b1, 4'h0, 2'd2, 1'b1);
      step(1'b0, 4'h0, 2'd2, 1'b1);
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 4'h0, 2'd1, 1'b1);
         if (bus_if.rd_valid === 1'b1 && bus_if.rd_addr === 4'h7) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL trst_reach_addr7 got=timeout exp=rd_addr 7");
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({bus_if.rd_addr, bus_if.rd_valid, bus_if.rd_sof, bus_if.rd_eof, bus_if.underrun, bus_if.overrun} !== 9'd0) begin
         failures++;
         $display("FAIL trst_async_clear got=%b exp=0", {bus_if.rd_addr, bus_if.rd_valid, bus_if.rd_sof,
                  bus_if.rd_eof, bus_if.underrun, bus_if.overrun});
      end
      repeat (2) @(negedge clk);
      clear_log();
      reset = 1'b0;
      repeat (20) step(1'b0, 4'h0, 2'd1, 1'b1);
      repeat (3) step(1'b0, 4'h0, 2'd0, 1'b0);
      checks++;
      if (evq.size() !== 0 || ur_cnt !== 0) begin
         failures++;
         $display("FAIL trst_quiet_after got reads=%0d underruns=%0d exp 0/0", evq.size(), ur_cnt);
      end
   endtask

   task automatic test_speed_change();
      logic [3:0] ea;
      clear_log();
      bus_if.speed = 2'b10;
      step(1'b1, 4'h2, 2'd2, 1'b1);
      step(1'b0, 4'h0, 2'd2, 1'b1);
      bus_if.speed = 2'b01;
      repeat (4) step(1'b0, 4'h0, 2'd1, 1'b1);
      repeat (10) step(1'b0, 4'h0, 2'd0, 1'b0);
      checks++;
      if (evq.size() !== 8) begin
         failures++;
         $display("FAIL tspd_count got=%0d exp=8", evq.size());
      end else begin
         ea = 4'h2;
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (evq[i].addr !== ea || evq[i].cyc !== evq[0].cyc + i || evq[i].eof !== (i == 7)) begin
               failures++;
               $display("FAIL tspd_beat%0d got addr=%h cyc=+%0d eof=%b exp addr=%h cyc=+%0d",
                        i, evq[i].addr, evq[i].cyc - evq[0].cyc, evq[i].eof, ea, i);
            end
            ea = ea + 4'd1;
         end
      end
      run_frame6_100m(4'h5, "tspd_next");
   endtask

   // speed 11 runs at gigabit; wr_cnt 3 counts as 2 bytes
   task automatic test_wrcnt3();
      logic [3:0] ea;
      clear_log();
      bus_if.speed = 2'b11;
      step(1'b1, 4'h2, 2'd3, 1'b1);
      step(1'b0, 4'h0, 2'd3, 1'b0);
      repeat (10) step(1'b0, 4'h0, 2'd0, 1'b0);
      checks++;
      if (evq.size() !== 4) begin
         failures++;
         $display("FAIL tw3_count got=%0d exp=4", evq.size());
      end else begin
         ea = 4'h2;
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (evq[i].addr !== ea || evq[i].cyc !== evq[0].cyc + i ||
                evq[i].sof !== (i == 0) || evq[i].eof !== (i == 3)) begin
               failures++;
               $display("FAIL tw3_beat%0d got addr=%h sof=%b eof=%b exp addr=%h", i,
                        evq[i].addr, evq[i].sof, evq[i].eof, ea);
            end
            ea = ea + 4'd1;
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      clear_log();
      test_reset();
      test_1000m();
      test_100m();
      test_underrun();
      test_overrun();
      test_reset_midframe();
      test_speed_change();
      test_wrcnt3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
